// File: rtl/gpr_dump_reader.sv
// Debug/trace reader: walks the general-purpose register file two entries per
// read cycle and streams each value as an indexed valid/ready beat.
module gpr_dump_reader #(
    parameter int unsigned XLEN     = 64,
    parameter int unsigned NUM_REGS = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            abort,
    output logic [4:0]      r1_id,
    output logic [4:0]      r2_id,
    input  logic [XLEN-1:0] r1,
    input  logic [XLEN-1:0] r2,
    output logic            dump_valid,
    input  logic            dump_ready,
    output logic [XLEN-1:0] dump_data,
    output logic [4:0]      dump_idx,
    output logic            busy,
    output logic            done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_EMIT0,
        S_EMIT1,
        S_DONE
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [3:0]      r_pair;
    logic [XLEN-1:0] r_slot0;
    logic [XLEN-1:0] r_slot1;
    logic            w_hs;
    logic            w_last;

    assign w_hs   = dump_valid && dump_ready;
    assign w_last = ({r_pair, 1'b1} == 5'(NUM_REGS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        if (abort) begin
            w_next = S_IDLE;
        end else begin
            unique case (r_state)
                S_IDLE:  if (start) w_next = S_READ;
                S_READ:  w_next = S_EMIT0;
                S_EMIT0: if (w_hs) w_next = S_EMIT1;
                S_EMIT1: if (w_hs) w_next = w_last ? S_DONE : S_READ;
                S_DONE:  w_next = S_IDLE;
                default: w_next = S_IDLE;
            endcase
        end
    end

    // Slots hold the pair as read in READ; later register writes do not leak in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pair  <= '0;
            r_slot0 <= '0;
            r_slot1 <= '0;
        end else if (!abort) begin
            if (r_state == S_IDLE && start) begin
                r_pair <= '0;
            end
            if (r_state == S_READ) begin
                r_slot0 <= r1;
                r_slot1 <= r2;
            end
            if (r_state == S_EMIT1 && w_hs && !w_last) begin
                r_pair <= r_pair + 4'd1;
            end
        end
    end

    always_comb begin
        r1_id      = '0;
        r2_id      = '0;
        dump_valid = 1'b0;
        dump_data  = '0;
        dump_idx   = '0;
        busy       = (r_state != S_IDLE);
        done       = (r_state == S_DONE);
        unique case (r_state)
            S_READ: begin
                r1_id = {r_pair, 1'b0};
                r2_id = {r_pair, 1'b1};
            end
            S_EMIT0: begin
                dump_valid = 1'b1;
                dump_data  = r_slot0;
                dump_idx   = {r_pair, 1'b0};
            end
            S_EMIT1: begin
                dump_valid = 1'b1;
                dump_data  = r_slot1;
                dump_idx   = {r_pair, 1'b1};
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_gpr_dump_reader.sv
// Directed bench for gpr_dump_reader with a bypassing register-file model.
module tb_gpr_dump_reader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [4:0]  r1_id;
    logic [4:0]  r2_id;
    logic [63:0] r1;
    logic [63:0] r2;
    logic        dump_valid;
    logic        dump_ready;
    logic [63:0] dump_data;
    logic [4:0]  dump_idx;
    logic        busy;
    logic        done;

    logic [63:0] rf [32];
    logic        wr_en;
    logic [4:0]  wr_idx;
    logic [63:0] wr_data;

    int n_checks = 0;
    int n_pass   = 0;

    // per-run observations
    int          nbeats;
    logic [4:0]  beat_idx  [64];
    logic [63:0] beat_data [64];
    int          beat_cyc  [64];
    int          done_cyc;
    int          done_count;
    int          busy_last;
    int          valid_last;
    int          id_viol;
    int          stall_cnt;
    int          held_bad;
    // stimulus hooks
    int          xs0, xs1;
    int          wcyc [2];
    logic [4:0]  widx [2];
    logic [63:0] wdat [2];

    always #5 clk = ~clk;

    assign r1 = (wr_en && wr_idx == r1_id && wr_idx != 5'd0) ? wr_data : rf[r1_id];
    assign r2 = (wr_en && wr_idx == r2_id && wr_idx != 5'd0) ? wr_data : rf[r2_id];

    gpr_dump_reader #(.XLEN(64), .NUM_REGS(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .r1_id     (r1_id),
        .r2_id     (r2_id),
        .r1        (r1),
        .r2        (r2),
        .dump_valid(dump_valid),
        .dump_ready(dump_ready),
        .dump_data (dump_data),
        .dump_idx  (dump_idx),
        .busy      (busy),
        .done      (done)
    );

    function automatic logic [63:0] exp_val(input int i);
        return (i == 0) ? 64'd0 : 64'hA5A5_0000_0000_0000 + 64'(i);
    endfunction

    task automatic preload();
        for (int i = 0; i < 32; i++) rf[i] = exp_val(i);
        xs0 = -1; xs1 = -1;
        wcyc[0] = -1; wcyc[1] = -1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one dump starting with start high in cycle 0; records accepted beats.
    task automatic run_dump(input int mode, input int abort_cyc, input int max_cyc);
        nbeats = 0; done_cyc = -1; done_count = 0; busy_last = -1;
        valid_last = -1; id_viol = 0; stall_cnt = 0; held_bad = 0;
        for (int c = 0; c <= max_cyc; c++) begin
            start  = (c == 0 || c == xs0 || c == xs1);
            abort  = (c == abort_cyc);
            wr_en  = 1'b0;
            for (int w = 0; w < 2; w++) begin
                if (c == wcyc[w]) begin
                    wr_en = 1'b1; wr_idx = widx[w]; wr_data = wdat[w];
                end
            end
            case (mode)
                1: begin
                    if (dump_valid && dump_idx == 5'd7 && stall_cnt < 5) begin
                        dump_ready = 1'b0;
                        stall_cnt++;
                        if (dump_data !== exp_val(7)) held_bad++;
                    end else begin
                        dump_ready = 1'b1;
                    end
                end
                2: dump_ready = 1'($urandom_range(0, 1));
                default: dump_ready = 1'b1;
            endcase
            #1;
            if ((r1_id != 5'd0 || r2_id != 5'd0) && !(busy && !dump_valid && !done)) id_viol++;
            if (done) begin done_count++; done_cyc = c; end
            if (busy) busy_last = c;
            if (dump_valid) valid_last = c;
            if (dump_valid && dump_ready && !abort && nbeats < 64) begin
                beat_idx[nbeats]  = dump_idx;
                beat_data[nbeats] = dump_data;
                beat_cyc[nbeats]  = c;
                nbeats++;
            end
            @(posedge clk);
            #1;
            if (wr_en && wr_idx != 5'd0) rf[wr_idx] = wr_data;
            wr_en = 1'b0; start = 1'b0; abort = 1'b0;
        end
        dump_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; dump_ready = 1'b0; wr_en = 1'b0;
        wr_idx = '0; wr_data = '0;
        preload();
        #3;
        n_checks++;
        if ({dump_valid, dump_data, dump_idx, r1_id, r2_id, busy, done} !== '0)
            $display("FAIL reset_outputs: got v=%b d=%h i=%0d r1=%0d r2=%0d b=%b dn=%b, want all 0",
                     dump_valid, dump_data, dump_idx, r1_id, r2_id, busy, done);
        else n_pass++;
        #4 rst_n = 1'b1;
        tick();
    endtask

    task automatic test_full_dump();
        int bad;
        preload();
        run_dump(0, -1, 55);
        n_checks++;
        if (nbeats !== 32) $display("FAIL full_beats: got %0d, want 32", nbeats);
        else n_pass++;
        bad = 0;
        for (int i = 0; i < 32 && i < nbeats; i++) begin
            if (beat_idx[i] !== 5'(i) || beat_data[i] !== exp_val(i) ||
                beat_cyc[i] !== 3 * (i / 2) + 2 + (i % 2)) begin
                if (bad == 0)
                    $display("FAIL full_beat%0d: got idx=%0d data=%h cyc=%0d, want idx=%0d data=%h cyc=%0d",
                             i, beat_idx[i], beat_data[i], beat_cyc[i], i, exp_val(i), 3 * (i / 2) + 2 + (i % 2));
                bad++;
            end
        end
        n_checks++;
        if (bad != 0) $display("FAIL full_data: %0d bad beats, want 0", bad);
        else n_pass++;
        n_checks++;
        if (done_count !== 1 || done_cyc !== 49)
            $display("FAIL full_done: got count=%0d cyc=%0d, want 1 at 49", done_count, done_cyc);
        else n_pass++;
        n_checks++;
        if (busy_last !== 49) $display("FAIL full_busy: last busy cyc %0d, want 49", busy_last);
        else n_pass++;
        n_checks++;
        if (id_viol !== 0) $display("FAIL full_ids: %0d non-READ id cycles, want 0", id_viol);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        int bad;
        preload();
        run_dump(1, -1, 60);
        n_checks++;
        if (stall_cnt !== 5 || held_bad !== 0)
            $display("FAIL bp_hold: stalls=%0d held_bad=%0d, want 5 and 0", stall_cnt, held_bad);
        else n_pass++;
        bad = 0;
        for (int i = 0; i < nbeats; i++)
            if (beat_idx[i] !== 5'(i) || beat_data[i] !== exp_val(i)) bad++;
        n_checks++;
        if (nbeats !== 32 || bad !== 0) $display("FAIL bp_seq: beats=%0d bad=%0d, want 32 and 0", nbeats, bad);
        else n_pass++;
        n_checks++;
        if (nbeats > 8 && beat_cyc[8] !== 19) $display("FAIL bp_resume: idx8 at cyc %0d, want 19", beat_cyc[8]);
        else if (nbeats > 8) n_pass++;
        else $display("FAIL bp_resume: only %0d beats, want idx8 at cyc 19", nbeats);
        n_checks++;
        if (done_count !== 1 || done_cyc !== 54)
            $display("FAIL bp_done: got count=%0d cyc=%0d, want 1 at 54", done_count, done_cyc);
        else n_pass++;
    endtask

    task automatic test_random_ready();
        int bad;
        preload();
        run_dump(2, -1, 400);
        bad = 0;
        for (int i = 0; i < nbeats; i++)
            if (beat_idx[i] !== 5'(i) || beat_data[i] !== exp_val(i)) bad++;
        n_checks++;
        if (nbeats !== 32 || bad !== 0) $display("FAIL rnd_seq: beats=%0d bad=%0d, want 32 and 0", nbeats, bad);
        else n_pass++;
        n_checks++;
        if (done_count !== 1) $display("FAIL rnd_done: got %0d done pulses, want 1", done_count);
        else n_pass++;
        n_checks++;
        if (id_viol !== 0) $display("FAIL rnd_ids: %0d non-READ id cycles, want 0", id_viol);
        else n_pass++;
    endtask

    task automatic test_concurrent_write();
        int bad;
        preload();
        wcyc[0] = 7; widx[0] = 5'd5; wdat[0] = 64'h0000_0000_DEAD_BEEF;
        wcyc[1] = 8; widx[1] = 5'd4; wdat[1] = 64'h1111_2222_3333_4444;
        run_dump(0, -1, 55);
        n_checks++;
        if (nbeats < 6 || beat_data[5] !== 64'h0000_0000_DEAD_BEEF)
            $display("FAIL wr_bypass: idx5 data=%h, want 00000000deadbeef", beat_data[5]);
        else n_pass++;
        n_checks++;
        if (nbeats < 5 || beat_data[4] !== exp_val(4))
            $display("FAIL wr_old: idx4 data=%h, want %h", beat_data[4], exp_val(4));
        else n_pass++;
        bad = 0;
        for (int i = 6; i < nbeats; i++)
            if (beat_data[i] !== exp_val(i)) bad++;
        n_checks++;
        if (nbeats !== 32 || bad !== 0) $display("FAIL wr_rest: beats=%0d bad=%0d, want 32 and 0", nbeats, bad);
        else n_pass++;
    endtask

    task automatic test_start_while_busy();
        int bad;
        preload();
        xs0 = 10; xs1 = 30;
        run_dump(0, -1, 60);
        bad = 0;
        for (int i = 0; i < nbeats; i++)
            if (beat_idx[i] !== 5'(i) || beat_data[i] !== exp_val(i) ||
                beat_cyc[i] !== 3 * (i / 2) + 2 + (i % 2)) bad++;
        n_checks++;
        if (nbeats !== 32 || bad !== 0) $display("FAIL busy_start_seq: beats=%0d bad=%0d, want 32 and 0", nbeats, bad);
        else n_pass++;
        n_checks++;
        if (done_count !== 1 || done_cyc !== 49 || busy_last !== 49)
            $display("FAIL busy_start_done: count=%0d done=%0d busy_last=%0d, want 1 49 49",
                     done_count, done_cyc, busy_last);
        else n_pass++;
    endtask

    task automatic test_abort_reset();
        int bad;
        preload();
        run_dump(0, 12, 20);
        n_checks++;
        if (nbeats !== 7 || done_count !== 0)
            $display("FAIL abort_beats: beats=%0d done=%0d, want 7 and 0", nbeats, done_count);
        else n_pass++;
        n_checks++;
        if (valid_last !== 12 || busy_last !== 12)
            $display("FAIL abort_idle: valid_last=%0d busy_last=%0d, want 12 12", valid_last, busy_last);
        else n_pass++;
        preload();
        run_dump(0, -1, 52);
        bad = 0;
        for (int i = 0; i < nbeats; i++)
            if (beat_idx[i] !== 5'(i) || beat_data[i] !== exp_val(i)) bad++;
        n_checks++;
        if (nbeats !== 32 || bad !== 0 || done_cyc !== 49)
            $display("FAIL abort_redump: beats=%0d bad=%0d done=%0d, want 32 0 49", nbeats, bad, done_cyc);
        else n_pass++;
        // start and abort together in IDLE stays IDLE
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        n_checks++;
        if (busy !== 1'b0) $display("FAIL start_abort_idle: busy=%b, want 0", busy);
        else n_pass++;
        // reset mid-dump, during READ of pair 1 (cycle 4)
        start = 1'b1; dump_ready = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        n_checks++;
        if (r1_id !== 5'd2 || r2_id !== 5'd3) $display("FAIL read_ids: got %0d/%0d, want 2/3", r1_id, r2_id);
        else n_pass++;
        #1 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({dump_valid, dump_data, dump_idx, r1_id, r2_id, busy, done} !== '0)
            $display("FAIL async_reset: v=%b d=%h i=%0d r1=%0d r2=%0d b=%b dn=%b, want all 0",
                     dump_valid, dump_data, dump_idx, r1_id, r2_id, busy, done);
        else n_pass++;
        #1 rst_n = 1'b1;
        tick(); tick();
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0) $display("FAIL post_reset_idle: busy=%b done=%b, want 0 0", busy, done);
        else n_pass++;
        dump_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_full_dump();
        test_backpressure();
        test_random_ready();
        test_concurrent_write();
        test_start_while_busy();
        test_abort_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
